// File: rtl/excitation_generator.sv
// Audio excitation source: impulse, rectangular burst or MLS noise, stepped by the sample
// strobe, followed by a silent capture tail. Framed by start_out / done_out pulses.

module excitation_generator #(
    parameter int unsigned             WIDTH      = 16,
    parameter logic signed [WIDTH-1:0] AMPLITUDE  = 16'shCFFF,
    parameter int unsigned             TAIL_STEPS = 256,
    parameter int unsigned             LFSR_ORDER = 16,
    parameter logic [LFSR_ORDER-1:0]   LFSR_TAPS  = 16'hB400
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    step_in,
    input  logic                    trigger_in,
    input  logic                    abort_in,
    input  logic [1:0]              mode_in,
    input  logic [15:0]             pulse_len_in,
    output logic                    busy_out,
    output logic                    start_out,
    output logic                    done_out,
    output logic signed [WIDTH-1:0] amp_out
);

    localparam int unsigned TailBits = $clog2(TAIL_STEPS + 1);
    localparam int unsigned CntBase  = (LFSR_ORDER > 16) ? LFSR_ORDER : 16;
    localparam int unsigned CntW     = (TailBits > CntBase) ? TailBits : CntBase;

    localparam logic [CntW-1:0]  MlsLen  = CntW'((64'd1 << LFSR_ORDER) - 64'd1);
    localparam logic [CntW-1:0]  TailLen = CntW'(TAIL_STEPS);
    localparam logic [CntW-1:0]  OneCnt  = CntW'(1);
    localparam logic [WIDTH-1:0] AmpPos  = AMPLITUDE;
    localparam logic [WIDTH-1:0] AmpNeg  = -AMPLITUDE;

    localparam logic [1:0] ModeBurst = 2'd1;
    localparam logic [1:0] ModeMls   = 2'd2;

    typedef enum logic [1:0] {StIdle, StArmed, StActive, StTail} state_e;

    state_e                r_state, w_state_next;
    logic [CntW-1:0]       r_cnt, w_cnt_next;
    logic [CntW-1:0]       r_len, w_len_next;
    logic [LFSR_ORDER-1:0] r_lfsr, w_lfsr_next;
    logic                  r_mls, w_mls_next;
    logic [WIDTH-1:0]      r_amp, w_amp_next;
    logic                  r_start, w_start_next;
    logic                  r_done, w_done_next;

    logic [CntW-1:0]       w_trig_len;
    logic [WIDTH-1:0]      w_sample;
    logic [LFSR_ORDER-1:0] w_lfsr_adv;

    // Reserved mode 3 falls into the impulse (length 1) branch.
    always_comb begin
        w_trig_len = OneCnt;
        case (mode_in)
            ModeBurst: w_trig_len = (pulse_len_in == '0) ? OneCnt : CntW'(pulse_len_in);
            ModeMls:   w_trig_len = MlsLen;
            default:   w_trig_len = OneCnt;
        endcase
    end

    assign w_sample   = (r_mls && !r_lfsr[0]) ? AmpNeg : AmpPos;
    assign w_lfsr_adv = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_len_next   = r_len;
        w_lfsr_next  = r_lfsr;
        w_mls_next   = r_mls;
        w_amp_next   = r_amp;
        w_start_next = 1'b0;
        w_done_next  = 1'b0;

        if (r_state != StIdle && abort_in) begin
            w_state_next = StIdle;
            w_amp_next   = '0;
            w_cnt_next   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_amp_next = '0;
                    if (trigger_in) begin
                        w_len_next   = w_trig_len;
                        w_mls_next   = (mode_in == ModeMls);
                        w_lfsr_next  = '1;
                        w_cnt_next   = '0;
                        w_state_next = StArmed;
                    end
                end
                StArmed: begin
                    if (step_in) begin
                        w_amp_next   = w_sample;
                        w_lfsr_next  = w_lfsr_adv;
                        w_start_next = 1'b1;
                        // Single-sample runs skip ACTIVE; the tail then counts the
                        // strobe that silences the output as its first step.
                        if (r_len == OneCnt) begin
                            w_cnt_next   = '0;
                            w_state_next = StTail;
                        end else begin
                            w_cnt_next   = OneCnt;
                            w_state_next = StActive;
                        end
                    end
                end
                StActive: begin
                    if (step_in) begin
                        if (r_cnt == r_len) begin
                            // This strobe already starts the first silent sample.
                            w_amp_next   = '0;
                            w_cnt_next   = OneCnt;
                            w_state_next = StTail;
                        end else begin
                            w_amp_next  = w_sample;
                            w_lfsr_next = w_lfsr_adv;
                            w_cnt_next  = r_cnt + OneCnt;
                        end
                    end
                end
                StTail: begin
                    if (step_in) begin
                        w_amp_next = '0;
                        if (r_cnt == TailLen) begin
                            w_done_next  = 1'b1;
                            w_cnt_next   = '0;
                            w_state_next = StIdle;
                        end else begin
                            w_cnt_next = r_cnt + OneCnt;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_len   <= '0;
            r_lfsr  <= '1;
            r_mls   <= 1'b0;
            r_amp   <= '0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_len   <= w_len_next;
            r_lfsr  <= w_lfsr_next;
            r_mls   <= w_mls_next;
            r_amp   <= w_amp_next;
            r_start <= w_start_next;
            r_done  <= w_done_next;
        end
    end

    assign busy_out  = (r_state != StIdle);
    assign start_out = r_start;
    assign done_out  = r_done;
    assign amp_out   = r_amp;

endmodule

// File: tb/tb_excitation_generator.sv
// Randomized bench for excitation_generator: each run is checked strobe by strobe against a
// sample list built from the excitation rules (L active samples, TAIL_STEPS zeros, then done).

module tb_excitation_generator;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned TAIL  = 256;
    localparam int unsigned ORDER = 4;
    localparam logic [3:0]  TAPS  = 4'hC;
    localparam logic [15:0] AMP   = 16'hCFFF;

    logic             clk_in;
    logic             rst_in;
    logic             step_in;
    logic             trigger_in;
    logic             abort_in;
    logic [1:0]       mode_in;
    logic [15:0]      pulse_len_in;
    logic             busy_out;
    logic             start_out;
    logic             done_out;
    logic [WIDTH-1:0] amp_out;

    int n_checks;
    int n_fail;

    excitation_generator #(
        .WIDTH      (WIDTH),
        .AMPLITUDE  (16'shCFFF),
        .TAIL_STEPS (TAIL),
        .LFSR_ORDER (ORDER),
        .LFSR_TAPS  (TAPS)
    ) u_dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .step_in      (step_in),
        .trigger_in   (trigger_in),
        .abort_in     (abort_in),
        .mode_in      (mode_in),
        .pulse_len_in (pulse_len_in),
        .busy_out     (busy_out),
        .start_out    (start_out),
        .done_out     (done_out),
        .amp_out      (amp_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full excitation. abort_at < 0 runs to completion; noise scrambles mode/length
    // after the trigger and fires extra triggers while busy.
    task automatic run_exc(input logic [1:0] mode, input logic [15:0] len, input int abort_at,
                           input bit coincident, input bit noise);
        logic [15:0] exp_q[$];
        logic [15:0] amp_neg;
        logic [15:0] exp_amp;
        int          n_act;
        int          lfsr;
        int          n_pos;
        int          n_neg;
        int          gap;
        int          last;

        amp_neg = 16'h0 - AMP;
        if (mode == 2'd1)      n_act = (len == 16'd0) ? 1 : int'(len);
        else if (mode == 2'd2) n_act = (1 << ORDER) - 1;
        else                   n_act = 1;
        lfsr = (1 << ORDER) - 1;
        for (int k = 0; k < n_act; k++) begin
            if (mode == 2'd2) begin
                exp_q.push_back(((lfsr & 1) != 0) ? AMP : amp_neg);
                lfsr = (lfsr >> 1) ^ (((lfsr & 1) != 0) ? int'(TAPS) : 0);
            end else begin
                exp_q.push_back(AMP);
            end
        end
        last = n_act + int'(TAIL);

        @(negedge clk_in);
        trigger_in   = 1'b1;
        mode_in      = mode;
        pulse_len_in = len;
        step_in      = coincident;
        @(negedge clk_in);
        trigger_in = 1'b0;
        step_in    = 1'b0;
        if (noise) begin
            mode_in      = 2'($urandom);
            pulse_len_in = 16'($urandom);
        end
        check_val("trig_busy", 32'(busy_out), 32'd1);
        check_val("trig_amp", 32'(amp_out), 32'd0);
        check_val("trig_start", 32'(start_out), 32'd0);

        exp_amp = 16'h0;
        n_pos   = 0;
        n_neg   = 0;
        for (int s = 0; s <= last; s++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                trigger_in = noise && ($urandom_range(0, 7) == 0);
                @(negedge clk_in);
                trigger_in = 1'b0;
                check_val("gap_amp", 32'(amp_out), 32'(exp_amp));
                check_val("gap_start", 32'(start_out), 32'd0);
                check_val("gap_done", 32'(done_out), 32'd0);
                check_val("gap_busy", 32'(busy_out), 32'd1);
            end
            if (s == abort_at) begin
                abort_in   = 1'b1;
                step_in    = 1'($urandom_range(0, 1));
                trigger_in = 1'($urandom_range(0, 1));
                @(negedge clk_in);
                abort_in   = 1'b0;
                step_in    = 1'b0;
                trigger_in = 1'b0;
                check_val("abort_amp", 32'(amp_out), 32'd0);
                check_val("abort_busy", 32'(busy_out), 32'd0);
                check_val("abort_start", 32'(start_out), 32'd0);
                check_val("abort_done", 32'(done_out), 32'd0);
                repeat (3) begin
                    step_in = 1'b1;
                    @(negedge clk_in);
                    step_in = 1'b0;
                    check_val("post_abort_busy", 32'(busy_out), 32'd0);
                    check_val("post_abort_done", 32'(done_out), 32'd0);
                    check_val("post_abort_amp", 32'(amp_out), 32'd0);
                end
                return;
            end
            step_in = 1'b1;
            @(negedge clk_in);
            step_in = 1'b0;
            exp_amp = (s < n_act) ? exp_q[s] : 16'h0;
            check_val("step_amp", 32'(amp_out), 32'(exp_amp));
            check_val("step_start", 32'(start_out), 32'(s == 0));
            check_val("step_done", 32'(done_out), 32'(s == last));
            check_val("step_busy", 32'(busy_out), 32'(s != last));
            if (mode == 2'd2 && s < n_act) begin
                if (amp_out == AMP)     n_pos++;
                if (amp_out == amp_neg) n_neg++;
            end
        end
        if (mode == 2'd2) begin
            check_val("mls_pos", 32'(n_pos), 32'(1 << (ORDER - 1)));
            check_val("mls_neg", 32'(n_neg), 32'((1 << (ORDER - 1)) - 1));
        end
    endtask

    task automatic reset_mid_run();
        @(negedge clk_in);
        trigger_in   = 1'b1;
        mode_in      = 2'd1;
        pulse_len_in = 16'd10;
        @(negedge clk_in);
        trigger_in = 1'b0;
        repeat (3) begin
            step_in = 1'b1;
            @(negedge clk_in);
            step_in = 1'b0;
        end
        check_val("pre_rst_amp", 32'(amp_out), 32'(AMP));
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        check_val("arst_amp", 32'(amp_out), 32'd0);
        check_val("arst_busy", 32'(busy_out), 32'd0);
        check_val("arst_start", 32'(start_out), 32'd0);
        check_val("arst_done", 32'(done_out), 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (5) begin
            step_in = 1'b1;
            @(negedge clk_in);
            step_in = 1'b0;
            @(negedge clk_in);
            check_val("idle_busy", 32'(busy_out), 32'd0);
            check_val("idle_amp", 32'(amp_out), 32'd0);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_in       = 1'b1;
        step_in      = 1'b0;
        trigger_in   = 1'b0;
        abort_in     = 1'b0;
        mode_in      = 2'd0;
        pulse_len_in = 16'd0;
        repeat (2) @(negedge clk_in);
        check_val("rst_amp", 32'(amp_out), 32'd0);
        check_val("rst_busy", 32'(busy_out), 32'd0);
        check_val("rst_start", 32'(start_out), 32'd0);
        check_val("rst_done", 32'(done_out), 32'd0);
        rst_in = 1'b0;

        run_exc(2'd0, 16'd0, -1, 1'b0, 1'b0);
        run_exc(2'd1, 16'd5, -1, 1'b0, 1'b0);
        run_exc(2'd1, 16'd0, -1, 1'b0, 1'b0);
        run_exc(2'd2, 16'd0, -1, 1'b0, 1'b0);
        run_exc(2'd2, 16'd0, -1, 1'b0, 1'b0);
        run_exc(2'd1, 16'd100, 41, 1'b0, 1'b0);
        run_exc(2'd1, 16'd7, -1, 1'b0, 1'b0);
        run_exc(2'd1, 16'd3, -1, 1'b1, 1'b1);
        run_exc(2'd3, 16'd9, -1, 1'b0, 1'b1);
        reset_mid_run();
        run_exc(2'd2, 16'd0, -1, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            logic [1:0]  m;
            logic [15:0] l;
            int          ab;
            m  = 2'($urandom);
            l  = 16'($urandom_range(0, 20));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
            run_exc(m, l, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/excitation_generator.md
# excitation_generator

Parametrised audio test-signal source for acoustic measurement. Supersedes the single-shot impulse generator. On a trigger it emits one of three excitations (impulse, rectangular burst, or maximum-length-sequence noise), aligned to the audio sample strobe. It then holds a silent capture tail and signals completion. It sits between the measurement controller (trigger/mode) and the DAC/mixer path (`amp_out`). `start_out` and `done_out` frame the capture window for the recorder.

## Interface
- `WIDTH`, 16: sample width, signed two's complement.
- `AMPLITUDE`, 16'shCFFF: excitation magnitude; must fit `WIDTH` and be negatable without overflow (not most-negative).
- `TAIL_STEPS`, 256: silent samples after the last active sample; ≥1.
- `LFSR_ORDER`, 16: MLS register length N; sequence length 2^N−1.
- `LFSR_TAPS`, 16'hB400: Galois feedback mask, N bits, maximal-length polynomial.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `step_in`  in  1  one-cycle audio sample strobe.
- `trigger_in`  in  1  start request; level or pulse, sampled only in IDLE.
- `abort_in`  in  1  cancel current excitation.
- `mode_in`  in  2  0 impulse, 1 burst, 2 MLS, 3 reserved (treated as impulse); latched at trigger.
- `pulse_len_in`  in  16  burst length in samples; latched at trigger; 0 treated as 1.
- `busy_out`  out  1  high in any state other than IDLE.
- `start_out`  out  1  one-cycle pulse on the cycle the first active sample appears on `amp_out`.
- `done_out`  out  1  one-cycle pulse at normal completion (not on abort).
- `amp_out`  out  `WIDTH`  signed sample output, registered.

## Operation
- States: IDLE → ARMED → ACTIVE → TAIL → IDLE.
- IDLE: `amp_out`=0. On `trigger_in` (and no `abort_in`), latch mode and length, load LFSR with all ones, clear counter, go to ARMED.
- ARMED: wait for `step_in`. On it, drive the first sample, pulse `start_out`, set counter=1, go to ACTIVE. If length is 1, go directly to TAIL with tail counter=0 instead.
- ACTIVE: on each `step_in`, drive the next sample and increment the counter. After the last active sample has been driven for one step, the next `step_in` drives 0 and enters TAIL.
- Sample rules:
  - Impulse: sample 0 = +`AMPLITUDE`; active length 1.
  - Burst: +`AMPLITUDE` for `pulse_len` samples.
  - MLS: sample = +`AMPLITUDE` if `lfsr[0]` else −`AMPLITUDE`. The LFSR advances each `step_in` as `next = (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0)`. Active length is 2^N−1.
- TAIL: `amp_out`=0. Count `TAIL_STEPS` `step_in` strobes. On the strobe that completes the count, pulse `done_out` and go to IDLE.
- `abort_in` in any non-IDLE state: next cycle `amp_out`=0, state IDLE, `start_out`/`done_out` low, no `done_out` pulse. Abort has priority over `step_in` and `trigger_in`.
- `trigger_in` while busy is ignored, not queued.
- Counter width: max(16, N, clog2(`TAIL_STEPS`+1)); no wrap within a run.

## Timing
- Reset, asynchronous: state IDLE, `amp_out`=0, `busy_out`=0, `start_out`=0, `done_out`=0, LFSR=all ones, counters 0.
- Trigger to ARMED: 1 cycle. `busy_out` rises the cycle after trigger is sampled.
- If `trigger_in` and `step_in` arrive in the same IDLE cycle, that strobe is not used. The first sample waits for the next `step_in`.
- First sample appears 1 cycle after the ARMED-state `step_in`, coincident with `start_out`.
- `amp_out` changes only on the cycle after a `step_in`, or on abort/reset.
- `done_out` and the return to IDLE occur on the same edge. `busy_out` is low on the `done_out` cycle.
- A new trigger is accepted in the cycle immediately following `done_out`.
- Reset mid-run takes effect immediately regardless of state.

## Test plan
- Impulse, default params: trigger, then `step_in` every 4 cycles. Required: `amp_out`=0xCFFF for exactly 1 step with `start_out` on that cycle, then 0 for 256 steps. `done_out` pulses on the 257th step after start, then IDLE.
- Burst, `pulse_len_in`=5: exactly 5 samples of 0xCFFF, then 256 zeros, then `done_out`. Repeat with `pulse_len_in`=0: exactly 1 sample.
- MLS with `LFSR_ORDER`=4, `LFSR_TAPS`=4'hC: exactly 15 samples with 8 positive and 7 negative. The sequence must match a reference Galois model, and the first sample is +`AMPLITUDE`. A second trigger reproduces the identical sequence.
- Abort mid-burst (`pulse_len_in`=100, abort at sample 40): `amp_out`=0 and `busy_out`=0 on the next cycle, no `done_out`. A following trigger runs normally.
- Trigger coincident with `step_in`; second trigger while busy. Required: first sample at the following strobe, not the coincident one; the second trigger has no effect.
- Async reset asserted between clock edges during ACTIVE: outputs go to zero without waiting for a clock. After release, the block idles until triggered.
